// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus (req/ready handshake, rvalid return).
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage owning the PC, one outstanding imem read, IF/ID register with skid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         inst_code,
  output logic [31:0]         inst_pc,
  output logic                inst_valid
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_code, r_ipc, r_skid_code, r_skid_pc;
  logic        r_valid, r_skid_valid;
  assign imem.req   = (r_state == S_FETCH) && !reset;
  assign imem.addr  = r_pc;
  assign inst_code  = r_code;
  assign inst_pc    = r_ipc;
  assign inst_valid = r_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_code       <= NOP_INST;
      r_ipc        <= 32'd0;
      r_valid      <= 1'b0;
      r_skid_code  <= NOP_INST;
      r_skid_pc    <= 32'd0;
      r_skid_valid <= 1'b0;
    end else if (redirect) begin
      // A request already in flight must have its response swallowed in DRAIN
      r_pc         <= redirect_pc & ~32'd3;
      r_code       <= NOP_INST;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
      r_state      <= ((r_state == S_WAIT && !imem.rvalid) || r_state == S_DRAIN) ? S_DRAIN : S_FETCH;
    end else begin
      if (!stall) begin
        r_valid <= 1'b0;
        r_code  <= NOP_INST;
      end
      case (r_state)
        S_FETCH: if (imem.ready) r_state <= S_WAIT;
        S_WAIT: if (imem.rvalid) begin
          r_pc <= r_pc + 32'd4;
          if (stall && r_valid) begin
            r_skid_code  <= imem.rdata;
            r_skid_pc    <= r_pc;
            r_skid_valid <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_code  <= imem.rdata;
            r_ipc   <= r_pc;
            r_valid <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_HOLD: if (!stall) begin
          r_code       <= r_skid_code;
          r_ipc        <= r_skid_pc;
          r_valid      <= r_skid_valid;
          r_skid_valid <= 1'b0;
          r_state      <= S_FETCH;
        end
        S_DRAIN: if (imem.rvalid) r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a hand-driven three-cycle imem.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk, reset, stall, redirect;
  logic [31:0] redirect_pc, inst_code, inst_pc;
  logic        inst_valid;
  int          n_chk = 0, n_fail = 0;
  fetch_unit_if imem();
  fetch_unit dut (
    .clk(clk), .reset(reset), .imem(imem), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_code(inst_code), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] code);
    chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, ".pc"}, inst_pc, pc);
    chk({tag, ".code"}, inst_code, code);
  endtask
  task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, imem.req}, {31'd0, r});
    chk({tag, ".addr"}, imem.addr, a);
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem.ready = 1'b1; imem.rvalid = 1'b0; imem.rdata = 32'd0;
    tick(); tick();
    chk_ifid("rst", 1'b0, 32'd0, NOP);
    chk_req("rst", 1'b0, 32'd0);
    // zero-wait memory, three cycles per instruction
    reset = 1'b0; #1;
    chk_req("c0", 1'b1, 32'h0);
    tick(); chk_req("c1", 1'b0, 32'h0);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0000;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("i0", 1'b1, 32'h0, 32'hA5A5_0000);
    chk_req("i0", 1'b1, 32'h4);
    tick(); chk_ifid("i0c", 1'b0, 32'h0, NOP);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0004;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("i1", 1'b1, 32'h4, 32'hA5A5_0004);
    chk_req("i1", 1'b1, 32'h8);
    tick(); chk_ifid("i1c", 1'b0, 32'h4, NOP);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0008;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("i2", 1'b1, 32'h8, 32'hA5A5_0008);
    chk_req("i2", 1'b1, 32'hC);
    // ready low for four cycles keeps the request stable
    imem.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_req("nrdy", 1'b1, 32'hC);
    end
    imem.ready = 1'b1;
    tick(); chk_req("hsC", 1'b0, 32'hC);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_000C;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("iC", 1'b1, 32'hC, 32'hA5A5_000C);
    // stall for five cycles while the next word returns into the skid buffer
    stall = 1'b1;
    tick(); chk_ifid("st0", 1'b1, 32'hC, 32'hA5A5_000C); chk_req("st0", 1'b0, 32'h10);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0010;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("st2", 1'b1, 32'hC, 32'hA5A5_000C); chk_req("st2", 1'b0, 32'h14);
    tick(); chk_ifid("st3", 1'b1, 32'hC, 32'hA5A5_000C); chk_req("st3", 1'b0, 32'h14);
    tick(); chk_ifid("st4", 1'b1, 32'hC, 32'hA5A5_000C); chk_req("st4", 1'b0, 32'h14);
    stall = 1'b0;
    tick(); chk_ifid("unst", 1'b1, 32'h10, 32'hA5A5_0010); chk_req("unst", 1'b1, 32'h14);
    // redirect while waiting, before rvalid
    tick(); chk_ifid("w14", 1'b0, 32'h10, NOP);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick(); redirect = 1'b0;
    chk_ifid("rdw", 1'b0, 32'h10, NOP); chk_req("rdw", 1'b0, 32'h100);
    imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("drn", 1'b0, 32'h10, NOP); chk_req("drn", 1'b1, 32'h100);
    tick(); chk_req("hs100", 1'b0, 32'h100);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0100;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("i100", 1'b1, 32'h100, 32'hA5A5_0100); chk_req("i100", 1'b1, 32'h104);
    // redirect and rvalid together under stall
    stall = 1'b1;
    tick(); chk_ifid("sw", 1'b1, 32'h100, 32'hA5A5_0100); chk_req("sw", 1'b0, 32'h104);
    imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0104; redirect = 1'b1; redirect_pc = 32'h200;
    tick(); imem.rvalid = 1'b0; redirect = 1'b0;
    chk({"rdv.valid"}, {31'd0, inst_valid}, 32'd0);
    chk({"rdv.code"}, inst_code, NOP);
    chk_req("rdv", 1'b1, 32'h200);
    // reset mid-WAIT with stall; late rvalid afterwards is ignored
    stall = 1'b0;
    tick(); chk_req("hs200", 1'b0, 32'h200);
    imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0200;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("i200", 1'b1, 32'h200, 32'hA5A5_0200);
    stall = 1'b1;
    tick(); chk_ifid("sw2", 1'b1, 32'h200, 32'hA5A5_0200); chk_req("sw2", 1'b0, 32'h204);
    reset = 1'b1; #1;
    chk_req("rstw", 1'b0, 32'h204);
    tick(); chk_ifid("rst2", 1'b0, 32'h0, NOP); chk_req("rst2", 1'b0, 32'h0);
    reset = 1'b0; stall = 1'b0; imem.ready = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF; #1;
    chk_req("post", 1'b1, 32'h0);
    tick(); imem.rvalid = 1'b0;
    chk_ifid("late", 1'b0, 32'h0, NOP); chk_req("late", 1'b1, 32'h0);
    imem.ready = 1'b1;
    tick(); chk_req("hs0", 1'b0, 32'h0);
    tick(); imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_0000;
    tick(); imem.rvalid = 1'b0;
    chk_ifid("r0", 1'b1, 32'h0, 32'hA5A5_0000); chk_req("r0", 1'b1, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
